// File: rtl/rd_vertex_offset_resp_pkg.sv
// Shared constants for the vertex-offset read-response stage.
// Holds the default widths, the result FIFO sizing and the bit positions
// of the start/end offset fields inside one offset-RAM word.
package rd_vertex_offset_resp_pkg;

  localparam int V_ID_WIDTH_DEF    = 20;
  localparam int V_VALUE_WIDTH_DEF = 32;
  localparam int V_OFF_AWIDTH_DEF  = 15;
  localparam int V_OFF_DWIDTH_DEF  = 64;
  localparam int RD_LAT_DEF        = 2;
  localparam int FIFO_DEPTH_DEF    = 16;
  localparam int FULL_MARGIN_DEF   = 4;

  // Offset word layout: upper half is the end offset, lower half the start.
  localparam int END_LSB   = 32;
  localparam int START_LSB = 0;

endpackage

// File: rtl/rd_vertex_offset_resp_fifo.sv
// offset_resp_fifo: synchronous FIFO holding processed vertex entries.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   wr_en, din    write strobe and entry
//   rd_en         pop strobe (caller only asserts it when not empty)
//   dout          registered popped entry, holds when no pop
//   dout_valid    one-cycle pulse when dout was loaded
//   count, empty  current occupancy and empty flag
module offset_resp_fifo
  import rd_vertex_offset_resp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  // A write into a full FIFO is still legal when a pop frees a slot in the same cycle.
  assign do_wr = wr_en && (!full || rd_en);
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= do_rd;
      if (do_rd) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: ;
      endcase
    end
  end

  // Upstream credit accounting must make this impossible.
  overflow_check: assert property (@(posedge clk) disable iff (!rst)
    !(wr_en && full && !rd_en));

endmodule

// File: rtl/rd_vertex_offset_resp.sv
// rd_vertex_offset_resp: issues the vertex-offset BRAM read for each active
// vertex, realigns the vertex sideband with the fixed-latency read data,
// splits the offset word into edge start / edge count and buffers the result
// in a credit-managed FIFO feeding the edge-read stage.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   front_*                       incoming vertex, its offset address, iteration end
//   next_stage_full               backpressure from the edge-read stage
//   v_off_rd_data                 BRAM data, RD_LAT cycles after the address
//   rd_v_off_addr, rd_v_off_en    BRAM read port
//   stage_full                    registered backpressure to the upstream stage
//   push_flag .. active_v_valid   buffered entry presented downstream
//   iteration_end(_valid)         iteration end, forwarded once fully drained
//   zero_deg_drop_cnt             only when OFFSET_ZERO_DEGREE_FILTER_EN is defined
// Build option OFFSET_ZERO_DEGREE_FILTER_EN: zero-degree vertices are dropped
// instead of buffered, and a saturating counter of dropped vertices is exposed.
module rd_vertex_offset_resp
  import rd_vertex_offset_resp_pkg::*;
#(
  parameter int V_ID_WIDTH    = V_ID_WIDTH_DEF,
  parameter int V_VALUE_WIDTH = V_VALUE_WIDTH_DEF,
  parameter int V_OFF_AWIDTH  = V_OFF_AWIDTH_DEF,
  parameter int V_OFF_DWIDTH  = V_OFF_DWIDTH_DEF,
  parameter int RD_LAT        = RD_LAT_DEF,
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
  parameter int FULL_MARGIN   = FULL_MARGIN_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        front_push_flag,
  input  logic [V_ID_WIDTH-1:0]       front_active_v_id,
  input  logic [V_VALUE_WIDTH-1:0]    front_active_v_value,
  input  logic [V_OFF_AWIDTH-1:0]     front_rd_active_v_offset_addr,
  input  logic                        front_active_v_pull_first_flag,
  input  logic                        front_active_v_id_valid,
  input  logic                        front_iteration_end,
  input  logic                        front_iteration_end_valid,
  input  logic                        next_stage_full,
  input  logic [V_OFF_DWIDTH-1:0]     v_off_rd_data,
  output logic [V_OFF_AWIDTH-1:0]     rd_v_off_addr,
  output logic                        rd_v_off_en,
  output logic                        stage_full,
  output logic                        push_flag,
  output logic [V_ID_WIDTH-1:0]       active_v_id,
  output logic [V_VALUE_WIDTH-1:0]    active_v_value,
  output logic                        active_v_pull_first_flag,
  output logic [V_OFF_DWIDTH/2-1:0]   active_v_edge_start,
  output logic [V_OFF_DWIDTH/2-1:0]   active_v_edge_num,
  output logic                        active_v_valid,
  output logic                        iteration_end,
  output logic                        iteration_end_valid
`ifdef OFFSET_ZERO_DEGREE_FILTER_EN
  ,
  output logic [31:0]                 zero_deg_drop_cnt
`endif
);

  localparam int HALF_W  = V_OFF_DWIDTH / 2;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W   = CNT_W + 1;
  localparam int ENTRY_W = 2 + V_ID_WIDTH + V_VALUE_WIDTH + 2 * HALF_W;
  localparam logic [OCC_W-1:0] FULL_THRESH = OCC_W'(FIFO_DEPTH - FULL_MARGIN);

  assign rd_v_off_en   = front_active_v_id_valid;
  assign rd_v_off_addr = front_rd_active_v_offset_addr;

  logic [RD_LAT-1:0]        pipe_valid;
  logic [RD_LAT-1:0]        pipe_push;
  logic [RD_LAT-1:0]        pipe_pf;
  logic [V_ID_WIDTH-1:0]    pipe_id    [RD_LAT];
  logic [V_VALUE_WIDTH-1:0] pipe_value [RD_LAT];

  // Sideband delay line matching the BRAM read latency; the last stage is
  // aligned with v_off_rd_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_valid <= '0;
      pipe_push  <= '0;
      pipe_pf    <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_id[i]    <= '0;
        pipe_value[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= front_active_v_id_valid;
      pipe_push[0]  <= front_push_flag;
      pipe_pf[0]    <= front_active_v_pull_first_flag;
      pipe_id[0]    <= front_active_v_id;
      pipe_value[0] <= front_active_v_value;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_push[i]  <= pipe_push[i-1];
        pipe_pf[i]    <= pipe_pf[i-1];
        pipe_id[i]    <= pipe_id[i-1];
        pipe_value[i] <= pipe_value[i-1];
      end
    end
  end

  logic [HALF_W-1:0] end_off;
  logic [HALF_W-1:0] start_off;
  logic [HALF_W-1:0] edge_num;
  logic              aligned_valid;

  assign aligned_valid = pipe_valid[RD_LAT-1];
  assign end_off       = v_off_rd_data[END_LSB +: HALF_W];
  assign start_off     = v_off_rd_data[START_LSB +: HALF_W];
  // A corrupt word with end below start is treated as a vertex with no edges.
  assign edge_num      = (end_off >= start_off) ? (end_off - start_off) : '0;

  logic               fifo_wr;
  logic               fifo_rd;
  logic               fifo_empty;
  logic               fifo_dout_valid;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;
  logic [CNT_W-1:0]   fifo_count;

`ifdef OFFSET_ZERO_DEGREE_FILTER_EN
  assign fifo_wr = aligned_valid && (edge_num != '0);

  // Saturating count of zero-degree vertices that were never buffered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zero_deg_drop_cnt <= '0;
    end else if (aligned_valid && (edge_num == '0) && (zero_deg_drop_cnt != '1)) begin
      zero_deg_drop_cnt <= zero_deg_drop_cnt + 32'd1;
    end
  end
`else
  assign fifo_wr = aligned_valid;
`endif

  assign fifo_din = {pipe_push[RD_LAT-1], pipe_id[RD_LAT-1], pipe_value[RD_LAT-1],
                     pipe_pf[RD_LAT-1], start_off, edge_num};
  assign fifo_rd  = !next_stage_full && !fifo_empty;

  offset_resp_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (fifo_wr),
    .din        (fifo_din),
    .rd_en      (fifo_rd),
    .dout       (fifo_dout),
    .dout_valid (fifo_dout_valid),
    .count      (fifo_count),
    .empty      (fifo_empty)
  );

  // The FIFO output register doubles as the stage output register.
  assign {push_flag, active_v_id, active_v_value, active_v_pull_first_flag,
          active_v_edge_start, active_v_edge_num} = fifo_dout;
  assign active_v_valid = fifo_dout_valid;

  logic [CNT_W-1:0] inflight;
  logic [OCC_W-1:0] occ;

  // Entries already launched at the BRAM hold a credit until they land.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CNT_W'(pipe_valid[i]);
    end
  end

  assign occ = OCC_W'(fifo_count) + OCC_W'(inflight);

  // Iteration end is only forwarded once nothing of the iteration remains here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_full          <= 1'b0;
      iteration_end       <= 1'b0;
      iteration_end_valid <= 1'b0;
    end else begin
      stage_full <= (occ >= FULL_THRESH);
      if (front_iteration_end && front_iteration_end_valid && (pipe_valid == '0) &&
          fifo_empty && !front_active_v_id_valid) begin
        iteration_end       <= 1'b1;
        iteration_end_valid <= 1'b1;
      end else begin
        iteration_end       <= 1'b0;
        iteration_end_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rd_vertex_offset_resp.sv
// Self-checking bench for rd_vertex_offset_resp: directed vertices drive a
// BRAM model; expected entries go into a scoreboard queue that a monitor
// drains whenever active_v_valid pulses.
module tb_rd_vertex_offset_resp;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        front_push_flag = 1'b0;
  logic [19:0] front_active_v_id = '0;
  logic [31:0] front_active_v_value = '0;
  logic [14:0] front_rd_active_v_offset_addr = '0;
  logic        front_active_v_pull_first_flag = 1'b0;
  logic        front_active_v_id_valid = 1'b0;
  logic        front_iteration_end = 1'b0;
  logic        front_iteration_end_valid = 1'b0;
  logic        next_stage_full = 1'b0;
  logic [63:0] v_off_rd_data;
  logic [14:0] rd_v_off_addr;
  logic        rd_v_off_en;
  logic        stage_full;
  logic        push_flag;
  logic [19:0] active_v_id;
  logic [31:0] active_v_value;
  logic        active_v_pull_first_flag;
  logic [31:0] active_v_edge_start;
  logic [31:0] active_v_edge_num;
  logic        active_v_valid;
  logic        iteration_end;
  logic        iteration_end_valid;
`ifdef OFFSET_ZERO_DEGREE_FILTER_EN
  logic [31:0] zero_deg_drop_cnt;
  int          exp_drops = 0;
`endif

  always #5 clk = ~clk;

  rd_vertex_offset_resp dut (
    .clk                            (clk),
    .rst                            (rst),
    .front_push_flag                (front_push_flag),
    .front_active_v_id              (front_active_v_id),
    .front_active_v_value           (front_active_v_value),
    .front_rd_active_v_offset_addr  (front_rd_active_v_offset_addr),
    .front_active_v_pull_first_flag (front_active_v_pull_first_flag),
    .front_active_v_id_valid        (front_active_v_id_valid),
    .front_iteration_end            (front_iteration_end),
    .front_iteration_end_valid      (front_iteration_end_valid),
    .next_stage_full                (next_stage_full),
    .v_off_rd_data                  (v_off_rd_data),
    .rd_v_off_addr                  (rd_v_off_addr),
    .rd_v_off_en                    (rd_v_off_en),
    .stage_full                     (stage_full),
    .push_flag                      (push_flag),
    .active_v_id                    (active_v_id),
    .active_v_value                 (active_v_value),
    .active_v_pull_first_flag       (active_v_pull_first_flag),
    .active_v_edge_start            (active_v_edge_start),
    .active_v_edge_num              (active_v_edge_num),
    .active_v_valid                 (active_v_valid),
    .iteration_end                  (iteration_end),
`ifdef OFFSET_ZERO_DEGREE_FILTER_EN
    .iteration_end_valid            (iteration_end_valid),
    .zero_deg_drop_cnt              (zero_deg_drop_cnt)
`else
    .iteration_end_valid            (iteration_end_valid)
`endif
  );

  // BRAM model: fixed RD_LAT-cycle read pipeline over an 8-word table.
  logic [63:0] ram [0:7];
  logic [63:0] ram_pipe [RD_LAT];
  logic [31:0] exp_start [0:7];
  logic [31:0] exp_num [0:7];

  always @(posedge clk) begin
    ram_pipe[0] <= ram[rd_v_off_addr[2:0]];
    for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign v_off_rd_data = ram_pipe[RD_LAT-1];

  typedef struct packed {
    logic        push;
    logic [19:0] id;
    logic [31:0] value;
    logic        pf;
    logic [31:0] start;
    logic [31:0] num;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   outputs_seen = 0;
  int   last_valid_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one vertex for the current cycle and records its expected result.
  task automatic applyStimulus(input logic [19:0] id, input logic [31:0] value,
                               input int addr, input logic push, input logic pf);
    exp_t e;
    front_active_v_id_valid        = 1'b1;
    front_active_v_id              = id;
    front_active_v_value           = value;
    front_rd_active_v_offset_addr  = 15'(addr);
    front_push_flag                = push;
    front_active_v_pull_first_flag = pf;
    e = '{push: push, id: id, value: value, pf: pf, start: exp_start[addr], num: exp_num[addr]};
`ifdef OFFSET_ZERO_DEGREE_FILTER_EN
    if (exp_num[addr] == 32'd0) exp_drops++;
    else sb.push_back(e);
`else
    sb.push_back(e);
`endif
  endtask

  task automatic waitDrain(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain_timeout: %0d entries still expected after %0d cycles", sb.size(), bound);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst && active_v_valid) begin
      outputs_seen++;
      last_valid_cyc = cyc;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_output: id 0x%0h with empty scoreboard", active_v_id);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("out_push", push_flag, mon_e.push);
        checkOutput("out_id", active_v_id, mon_e.id);
        checkOutput("out_value", active_v_value, mon_e.value);
        checkOutput("out_pull_first", active_v_pull_first_flag, mon_e.pf);
        checkOutput("out_edge_start", active_v_edge_start, mon_e.start);
        checkOutput("out_edge_num", active_v_edge_num, mon_e.num);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int issued;
    int loops;
    int n;
    int seen;
    int issue_cyc;
    bit seen_full;

    // Word = {end, start}; expected start and count worked out by hand.
    ram[0] = {32'd5, 32'd9};                 exp_start[0] = 32'd9;          exp_num[0] = 32'd0;
    ram[1] = {32'd10, 32'd10};               exp_start[1] = 32'd10;         exp_num[1] = 32'd0;
    ram[2] = {32'd100, 32'd40};              exp_start[2] = 32'd40;         exp_num[2] = 32'd60;
    ram[3] = {32'h0000_1000, 32'h0000_0800}; exp_start[3] = 32'h0000_0800;  exp_num[3] = 32'h0000_0800;
    ram[4] = {32'hFFFF_FFFF, 32'h0};         exp_start[4] = 32'h0;          exp_num[4] = 32'hFFFF_FFFF;
    ram[5] = {32'd7, 32'd6};                 exp_start[5] = 32'd6;          exp_num[5] = 32'd1;
    ram[6] = {32'h8000_0000, 32'h7FFF_FFFF}; exp_start[6] = 32'h7FFF_FFFF;  exp_num[6] = 32'd1;
    ram[7] = {32'd300, 32'd0};               exp_start[7] = 32'd0;          exp_num[7] = 32'd300;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", active_v_valid, 0);
    checkOutput("reset_stage_full", stage_full, 0);
    checkOutput("reset_iter_end", iteration_end, 0);
    checkOutput("reset_rd_en", rd_v_off_en, 0);
    rst = 1'b1;

    // Single vertex, no stall: check read port and latency.
    tick();
    issue_cyc = cyc;
    applyStimulus(20'h00041, 32'h1234_5678, 2, 1'b1, 1'b0);
    #1;
    checkOutput("rd_en", rd_v_off_en, 1);
    checkOutput("rd_addr", rd_v_off_addr, 2);
    tick();
    front_active_v_id_valid = 1'b0;
    waitDrain(50);
    checkOutput("latency", last_valid_cyc - issue_cyc, RD_LAT + 2);

    // 20 back-to-back vertices under stall, honouring stage_full.
    tick();
    next_stage_full = 1'b1;
    issued = 0;
    loops = 0;
    seen_full = 0;
    while (issued < 20 && loops < 2000) begin
      tick();
      loops++;
      if (loops == 30) checkOutput("stage_full_held", stage_full, 1);
      if (loops == 40) next_stage_full = 1'b0;
      if (stage_full) begin
        front_active_v_id_valid = 1'b0;
        if (!seen_full) begin
          seen_full = 1;
`ifndef OFFSET_ZERO_DEGREE_FILTER_EN
          checkOutput("accepted_before_full", issued, 13);
`endif
        end
      end else begin
        applyStimulus(20'h00100 + 20'(issued), 32'hA000_0000 + 32'(issued), issued % 8,
                      issued[0], issued[1]);
        issued++;
      end
    end
    tick();
    front_active_v_id_valid = 1'b0;
    checkOutput("bulk_issued", issued, 20);
    waitDrain(300);

    // Fill 15 entries, then one write coinciding with one pop.
    tick();
    next_stage_full = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      applyStimulus(20'h00200 + 20'(i), 32'hB000_0000 + 32'(i), 2 + (i % 6), 1'b0, 1'b1);
    end
    tick();
    front_active_v_id_valid = 1'b0;
    repeat (8) tick();
    applyStimulus(20'h0020F, 32'hB000_000F, 7, 1'b1, 1'b1);
    tick();
    front_active_v_id_valid = 1'b0;
    tick();
    next_stage_full = 1'b0;
    tick();
    next_stage_full = 1'b1;
    repeat (3) tick();
    checkOutput("stage_full_at_15", stage_full, 1);
    next_stage_full = 1'b0;
    waitDrain(200);

    // Zero-degree and clamped entries without stall.
    tick();
    applyStimulus(20'h00300, 32'hC000_0001, 1, 1'b0, 1'b0);
    tick();
    applyStimulus(20'h00301, 32'hC000_0002, 0, 1'b1, 1'b0);
    tick();
    front_active_v_id_valid = 1'b0;
    repeat (RD_LAT + 4) tick();
    waitDrain(50);
`ifdef OFFSET_ZERO_DEGREE_FILTER_EN
    checkOutput("zero_deg_drop_cnt", zero_deg_drop_cnt, 32'(exp_drops));
`endif

    // Iteration end held while 3 entries are buffered.
    next_stage_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      applyStimulus(20'h00400 + 20'(i), 32'hD000_0000 + 32'(i), 3 + i, 1'b1, 1'b0);
    end
    tick();
    front_active_v_id_valid = 1'b0;
    repeat (6) tick();
    front_iteration_end       = 1'b1;
    front_iteration_end_valid = 1'b1;
    repeat (3) tick();
    checkOutput("iter_end_while_buffered", iteration_end, 0);
    checkOutput("iter_end_valid_while_buffered", iteration_end_valid, 0);
    seen = outputs_seen;
    next_stage_full = 1'b0;
    n = 0;
    while (outputs_seen < seen + 3 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (outputs_seen < seen + 3) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL iter_drain_timeout: %0d of 3 outputs seen", outputs_seen - seen);
    end
    checkOutput("iter_end_at_last_pop", iteration_end, 0);
    @(negedge clk);
    #1;
    checkOutput("iter_end_after_drain", iteration_end, 1);
    checkOutput("iter_end_valid_after_drain", iteration_end_valid, 1);
    tick();
    front_iteration_end       = 1'b0;
    front_iteration_end_valid = 1'b0;
    tick();
    checkOutput("iter_end_deassert", iteration_end, 0);

    // Reset with 5 entries in flight/buffered.
    next_stage_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      applyStimulus(20'h00500 + 20'(i), 32'hE000_0000 + 32'(i), 7, 1'b1, 1'b1);
    end
    #2;
    rst = 1'b0;
    front_active_v_id_valid = 1'b0;
    #1;
    checkOutput("midreset_valid", active_v_valid, 0);
    checkOutput("midreset_id", active_v_id, 0);
    checkOutput("midreset_push", push_flag, 0);
    checkOutput("midreset_edge_num", active_v_edge_num, 0);
    checkOutput("midreset_stage_full", stage_full, 0);
    sb.delete();
`ifdef OFFSET_ZERO_DEGREE_FILTER_EN
    checkOutput("midreset_drop_cnt", zero_deg_drop_cnt, 0);
`endif
    repeat (3) tick();
    rst = 1'b1;
    next_stage_full = 1'b0;
    seen = outputs_seen;
    repeat (12) tick();
    checkOutput("no_stray_valid", outputs_seen - seen, 0);
    checkOutput("post_reset_stage_full", stage_full, 0);
    checkOutput("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
